// File: rtl/atm_ui_pkg.sv
// Shared codes for the ATM keyboard front end: entry styles, status codes,
// menu codes, ASCII key constants and the field-entry FSM encoding.
package atm_ui_pkg;

   localparam logic [3:0] STYLE_NONE            = 4'd0;
   localparam logic [3:0] STYLE_SINGLE_KEY      = 4'd1;
   localparam logic [3:0] STYLE_ACC_NUMBER      = 4'd2;
   localparam logic [3:0] STYLE_PIN_NUMBER      = 4'd3;
   localparam logic [3:0] STYLE_MENU_SELECTION  = 4'd4;
   localparam logic [3:0] STYLE_CURRENCY_TYPE   = 4'd5;
   localparam logic [3:0] STYLE_CURRENCY_AMOUNT = 4'd6;

   localparam logic [3:0] STATUS_NONE           = 4'b0000;
   localparam logic [3:0] STATUS_EXIT           = 4'b0111;
   localparam logic [3:0] STATUS_INPUT_COMPLETE = 4'b1000;
   localparam logic [3:0] STATUS_INPUT_INVALID  = 4'b1001;

   localparam logic [1:0] MENU_BALANCE  = 2'b00;
   localparam logic [1:0] MENU_CONVERT  = 2'b01;
   localparam logic [1:0] MENU_WITHDRAW = 2'b10;
   localparam logic [1:0] MENU_TRANSFER = 2'b11;

   localparam logic [7:0] KEY_BKSP   = 8'h08;
   localparam logic [7:0] KEY_ENTER  = 8'h0D;
   localparam logic [7:0] KEY_ESC    = 8'h1B;
   localparam logic [7:0] KEY_ZERO   = 8'h30;
   localparam logic [7:0] KEY_NINE   = 8'h39;
   localparam logic [7:0] KEY_MENU_B = 8'h62;
   localparam logic [7:0] KEY_MENU_C = 8'h63;
   localparam logic [7:0] KEY_MENU_T = 8'h74;
   localparam logic [7:0] KEY_MENU_W = 8'h77;
   localparam logic [7:0] KEY_QUIT   = 8'h71;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   function automatic logic style_active(input logic [3:0] s);
      return (s != STYLE_NONE) && (s <= STYLE_CURRENCY_AMOUNT);
   endfunction

   function automatic logic style_numeric(input logic [3:0] s);
      return (s == STYLE_ACC_NUMBER) || (s == STYLE_PIN_NUMBER) ||
             (s == STYLE_CURRENCY_AMOUNT);
   endfunction

endpackage

// File: rtl/ascii_key_decode.sv
// Combinational classifier for one ASCII key code: digit value, editing keys,
// quit key and menu letters with their menu code.
module ascii_key_decode
   import atm_ui_pkg::*;
(
   input  logic [7:0] ascii_code,
   output logic       is_digit,
   output logic [3:0] digit,
   output logic       is_enter,
   output logic       is_bksp,
   output logic       is_esc,
   output logic       is_quit,
   output logic       is_menu,
   output logic [1:0] menu_code
);

   always_comb begin
      is_digit  = (ascii_code >= KEY_ZERO) && (ascii_code <= KEY_NINE);
      // '0'..'9' carry their value in the low nibble
      digit     = is_digit ? ascii_code[3:0] : 4'd0;
      is_enter  = (ascii_code == KEY_ENTER);
      is_bksp   = (ascii_code == KEY_BKSP);
      is_esc    = (ascii_code == KEY_ESC);
      is_quit   = (ascii_code == KEY_QUIT);
      is_menu   = 1'b0;
      menu_code = MENU_BALANCE;
      case (ascii_code)
         KEY_MENU_B: begin is_menu = 1'b1; menu_code = MENU_BALANCE;  end
         KEY_MENU_C: begin is_menu = 1'b1; menu_code = MENU_CONVERT;  end
         KEY_MENU_W: begin is_menu = 1'b1; menu_code = MENU_WITHDRAW; end
         KEY_MENU_T: begin is_menu = 1'b1; menu_code = MENU_TRANSFER; end
         default: ;
      endcase
   end

endmodule

// File: rtl/ascii_field_entry.sv
// Keyboard field collector: registers each key strobe, then edits a BCD buffer
// or selection under a small IDLE/COLLECT/DONE FSM and pulses ready on commit.
module ascii_field_entry
   import atm_ui_pkg::*;
#(
   parameter  int MAX_DIGITS   = 8,
   parameter  int FIXED_DIGITS = 4,
   localparam int CW           = $clog2(MAX_DIGITS + 1)
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    key_valid,
   input  logic [7:0]              ascii_code,
   input  logic [3:0]              input_style,
   output logic                    ready,
   output logic [3:0]              status_code,
   output logic [4*MAX_DIGITS-1:0] value,
   output logic [CW-1:0]           digit_count,
   output logic [1:0]              menu_sel,
   output logic [2:0]              currency_sel
);

   localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_DIGITS);
   localparam logic [CW-1:0] FIXED_CNT = CW'(FIXED_DIGITS);

   logic                    key_valid_reg;
   logic [7:0]              ascii_reg;
   logic [3:0]              style_reg;
   logic [3:0]              mode_reg,         mode_next;
   state_t                  state_reg,        state_next;
   logic [4*MAX_DIGITS-1:0] value_reg,        value_next;
   logic [CW-1:0]           count_reg,        count_next;
   logic                    sel_made_reg,     sel_made_next;
   logic [1:0]              menu_sel_reg,     menu_sel_next;
   logic [2:0]              currency_sel_reg, currency_sel_next;
   logic [3:0]              status_reg,       status_next;
   logic                    ready_reg,        ready_next;

   logic       k_is_digit, k_is_enter, k_is_bksp, k_is_esc, k_is_quit, k_is_menu;
   logic [3:0] k_digit;
   logic [1:0] k_menu_code;

   ascii_key_decode u_decode (
      .ascii_code (ascii_reg),
      .is_digit   (k_is_digit),
      .digit      (k_digit),
      .is_enter   (k_is_enter),
      .is_bksp    (k_is_bksp),
      .is_esc     (k_is_esc),
      .is_quit    (k_is_quit),
      .is_menu    (k_is_menu),
      .menu_code  (k_menu_code)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         key_valid_reg    <= 1'b0;
         ascii_reg        <= 8'd0;
         style_reg        <= STYLE_NONE;
         mode_reg         <= STYLE_NONE;
         state_reg        <= ST_IDLE;
         value_reg        <= '0;
         count_reg        <= '0;
         sel_made_reg     <= 1'b0;
         menu_sel_reg     <= 2'd0;
         currency_sel_reg <= 3'd0;
         status_reg       <= STATUS_NONE;
         ready_reg        <= 1'b0;
      end else begin
         key_valid_reg    <= key_valid;
         ascii_reg        <= ascii_code;
         style_reg        <= input_style;
         mode_reg         <= mode_next;
         state_reg        <= state_next;
         value_reg        <= value_next;
         count_reg        <= count_next;
         sel_made_reg     <= sel_made_next;
         menu_sel_reg     <= menu_sel_next;
         currency_sel_reg <= currency_sel_next;
         status_reg       <= status_next;
         ready_reg        <= ready_next;
      end
   end

   logic                    numeric, cur_ok, edit_key, enter_ok;
   logic [CW-1:0]           limit;
   logic [4*MAX_DIGITS-1:0] base_value;
   logic [CW-1:0]           base_count;
   logic                    base_sel;
   logic [3:0]              base_status;

   always_comb begin
      mode_next         = mode_reg;
      state_next        = state_reg;
      value_next        = value_reg;
      count_next        = count_reg;
      sel_made_next     = sel_made_reg;
      menu_sel_next     = menu_sel_reg;
      currency_sel_next = currency_sel_reg;
      status_next       = status_reg;
      ready_next        = 1'b0;

      numeric  = style_numeric(mode_reg);
      limit    = (mode_reg == STYLE_CURRENCY_AMOUNT) ? MAX_CNT : FIXED_CNT;
      cur_ok   = k_is_digit && (k_digit >= 4'd1) && (k_digit <= 4'd5);
      edit_key = (numeric && (k_is_digit || k_is_bksp || k_is_esc)) ||
                 ((mode_reg == STYLE_MENU_SELECTION) && k_is_menu) ||
                 ((mode_reg == STYLE_CURRENCY_TYPE) && cur_ok);

      case (mode_reg)
         STYLE_SINGLE_KEY:                       enter_ok = 1'b1;
         STYLE_ACC_NUMBER, STYLE_PIN_NUMBER:     enter_ok = (count_reg == FIXED_CNT);
         STYLE_CURRENCY_AMOUNT:                  enter_ok = (count_reg != '0);
         STYLE_MENU_SELECTION, STYLE_CURRENCY_TYPE: enter_ok = sel_made_reg;
         default:                                enter_ok = 1'b0;
      endcase

      // A fresh entry (from IDLE or DONE) starts from an empty buffer
      if (state_reg == ST_COLLECT) begin
         base_value  = value_reg;
         base_count  = count_reg;
         base_sel    = sel_made_reg;
         base_status = status_reg;
      end else begin
         base_value  = '0;
         base_count  = '0;
         base_sel    = 1'b0;
         base_status = STATUS_NONE;
      end

      if (style_reg != mode_reg) begin
         // Mode change aborts the entry and swallows any key sampled with it
         mode_next     = style_reg;
         state_next    = ST_IDLE;
         value_next    = '0;
         count_next    = '0;
         sel_made_next = 1'b0;
         status_next   = STATUS_NONE;
      end else if (key_valid_reg && style_active(mode_reg)) begin
         if (k_is_quit) begin
            state_next    = ST_IDLE;
            value_next    = '0;
            count_next    = '0;
            sel_made_next = 1'b0;
            status_next   = STATUS_EXIT;
            ready_next    = 1'b1;
         end else if (k_is_enter) begin
            if (enter_ok) begin
               state_next  = ST_DONE;
               status_next = STATUS_INPUT_COMPLETE;
               ready_next  = 1'b1;
            end else begin
               status_next = STATUS_INPUT_INVALID;
            end
         end else if (edit_key) begin
            state_next    = ST_COLLECT;
            value_next    = base_value;
            count_next    = base_count;
            sel_made_next = base_sel;
            status_next   = base_status;
            if (numeric && k_is_digit) begin
               if (base_count < limit) begin
                  value_next  = {base_value[4*MAX_DIGITS-5:0], k_digit};
                  count_next  = base_count + CW'(1);
                  status_next = STATUS_NONE;
               end
            end else if (numeric && k_is_bksp) begin
               if (base_count != '0) begin
                  value_next  = base_value >> 4;
                  count_next  = base_count - CW'(1);
                  status_next = STATUS_NONE;
               end
            end else if (numeric && k_is_esc) begin
               value_next  = '0;
               count_next  = '0;
               status_next = STATUS_NONE;
            end else if (k_is_menu) begin
               menu_sel_next = k_menu_code;
               sel_made_next = 1'b1;
               status_next   = STATUS_NONE;
            end else begin
               currency_sel_next = 3'(k_digit - 4'd1);
               sel_made_next     = 1'b1;
               status_next       = STATUS_NONE;
            end
         end
      end
   end

   assign ready        = ready_reg;
   assign status_code  = status_reg;
   assign value        = value_reg;
   assign digit_count  = count_reg;
   assign menu_sel     = menu_sel_reg;
   assign currency_sel = currency_sel_reg;

endmodule

// File: tb/tb_ascii_field_entry.sv
// Directed plus randomized bench for ascii_field_entry, checked against a
// queue-based model of the entry rules.
module tb_ascii_field_entry;
   import atm_ui_pkg::*;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          key_valid;
   logic [7:0]    ascii_code;
   logic [3:0]    input_style;
   logic          ready;
   logic [3:0]    status_code;
   logic [31:0]   value;
   logic [CW-1:0] digit_count;
   logic [1:0]    menu_sel;
   logic [2:0]    currency_sel;

   ascii_field_entry #(.MAX_DIGITS(8), .FIXED_DIGITS(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_valid    (key_valid),
      .ascii_code   (ascii_code),
      .input_style  (input_style),
      .ready        (ready),
      .status_code  (status_code),
      .value        (value),
      .digit_count  (digit_count),
      .menu_sel     (menu_sel),
      .currency_sel (currency_sel)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // reference model: digits held as a queue, first typed at index 0
   logic [3:0] m_mode;
   int         m_buf[$];
   bit         m_open;
   bit         m_sel;
   logic [1:0] m_menu;
   logic [2:0] m_cur;
   logic [3:0] m_status;
   bit         m_ready;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_value();
      logic [31:0] v = 32'd0;
      foreach (m_buf[i]) v = (v << 4) | 32'(m_buf[i]);
      return v;
   endfunction

   task automatic check_all(input string tag);
      check({tag, ".value"},  value,               m_value());
      check({tag, ".count"},  32'(digit_count),    32'(m_buf.size()));
      check({tag, ".status"}, 32'(status_code),    32'(m_status));
      check({tag, ".ready"},  32'(ready),          32'(m_ready));
      check({tag, ".menu"},   32'(menu_sel),       32'(m_menu));
      check({tag, ".cur"},    32'(currency_sel),   32'(m_cur));
   endtask

   task automatic model_reset();
      m_mode = 4'd0; m_buf.delete(); m_open = 0; m_sel = 0;
      m_menu = 2'd0; m_cur = 3'd0; m_status = 4'd0; m_ready = 0;
   endtask

   task automatic model_abort(input logic [3:0] s);
      m_mode = s; m_buf.delete(); m_open = 0; m_sel = 0;
      m_status = 4'd0; m_ready = 0;
   endtask

   task automatic model_key(input logic [7:0] c);
      bit is_dig, numeric, edit, ok;
      int d, lim, midx;
      m_ready = 0;
      if (m_mode >= 4'd1 && m_mode <= 4'd6) begin
         is_dig  = (c >= "0") && (c <= "9");
         d       = int'(c) - 48;
         numeric = (m_mode == 4'd2) || (m_mode == 4'd3) || (m_mode == 4'd6);
         lim     = (m_mode == 4'd6) ? 8 : 4;
         case (c)
            "b": midx = 0;
            "c": midx = 1;
            "w": midx = 2;
            "t": midx = 3;
            default: midx = -1;
         endcase
         if (c == 8'h71) begin
            m_status = 4'b0111; m_ready = 1; m_buf.delete(); m_open = 0; m_sel = 0;
         end else if (c == 8'h0D) begin
            case (m_mode)
               4'd1:       ok = 1;
               4'd2, 4'd3: ok = (m_buf.size() == 4);
               4'd6:       ok = (m_buf.size() >= 1);
               default:    ok = m_sel;
            endcase
            if (ok) begin
               m_ready = 1; m_status = 4'b1000; m_open = 0;
            end else begin
               m_status = 4'b1001;
            end
         end else begin
            edit = (numeric && (is_dig || c == 8'h08 || c == 8'h1B)) ||
                   (m_mode == 4'd4 && midx >= 0) ||
                   (m_mode == 4'd5 && is_dig && d >= 1 && d <= 5);
            if (edit) begin
               if (!m_open) begin
                  m_buf.delete(); m_sel = 0; m_status = 4'd0; m_open = 1;
               end
               if (numeric && is_dig) begin
                  if (m_buf.size() < lim) begin m_buf.push_back(d); m_status = 4'd0; end
               end else if (numeric && c == 8'h08) begin
                  if (m_buf.size() > 0) begin void'(m_buf.pop_back()); m_status = 4'd0; end
               end else if (numeric && c == 8'h1B) begin
                  m_buf.delete(); m_status = 4'd0;
               end else if (midx >= 0) begin
                  m_menu = 2'(midx); m_sel = 1; m_status = 4'd0;
               end else begin
                  m_cur = 3'(d - 1); m_sel = 1; m_status = 4'd0;
               end
            end
         end
      end
   endtask

   // Each step begins just after a falling edge
   task automatic send_key(input logic [7:0] c, input bit valid, input string tag);
      key_valid = valid; ascii_code = c;
      @(negedge clk);
      key_valid = 1'b0;
      check({tag, ".pulse_gap"}, 32'(ready), 32'd0);
      @(negedge clk);
      if (valid) model_key(c); else m_ready = 0;
      check_all(tag);
   endtask

   task automatic set_style(input logic [3:0] s, input bit with_key, input logic [7:0] c,
                            input string tag);
      input_style = s; key_valid = with_key; ascii_code = c;
      @(negedge clk);
      key_valid = 1'b0;
      @(negedge clk);
      if (s != m_mode) model_abort(s);
      else if (with_key) model_key(c);
      else m_ready = 0;
      check_all(tag);
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      @(negedge clk);
      model_reset();
      check_all(tag);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

   logic [7:0] pool [20] = '{"0", "1", "2", "3", "4", "5", "6", "7", "8", "9",
                             8'h0D, 8'h0D, 8'h08, 8'h1B, 8'h71,
                             "b", "c", "w", "t", "A"};

   initial begin
      rst_n = 1'b0; key_valid = 1'b0; ascii_code = 8'd0; input_style = 4'd0;
      model_reset();
      repeat (3) @(negedge clk);
      check_all("reset");
      rst_n = 1'b1;
      @(negedge clk);

      set_style(STYLE_ACC_NUMBER, 0, 8'd0, "acc_mode");
      send_key("1", 1, "acc_1");
      send_key("2", 1, "acc_2");
      send_key("3", 1, "acc_3");
      send_key("4", 1, "acc_4");
      send_key(8'h0D, 1, "acc_enter");
      send_key(8'h00, 0, "acc_hold");

      set_style(STYLE_PIN_NUMBER, 0, 8'd0, "pin_mode");
      send_key("5", 1, "pin_5");
      send_key("6", 1, "pin_6");
      send_key(8'h0D, 1, "pin_enter_short");
      send_key("7", 1, "pin_7");
      send_key("8", 1, "pin_8");
      send_key("9", 1, "pin_9_limit");
      send_key(8'h0D, 1, "pin_enter");

      set_style(STYLE_CURRENCY_AMOUNT, 0, 8'd0, "amt_mode");
      for (int i = 0; i < 9; i++) send_key("9", 1, $sformatf("amt_9_%0d", i));
      send_key(8'h08, 1, "amt_bksp1");
      send_key(8'h08, 1, "amt_bksp2");
      send_key("1", 1, "amt_1");
      send_key(8'h0D, 1, "amt_enter");

      set_style(STYLE_MENU_SELECTION, 0, 8'd0, "menu_mode");
      send_key(8'h0D, 1, "menu_enter_empty");
      send_key("w", 1, "menu_w");
      send_key("t", 1, "menu_t");
      send_key(8'h0D, 1, "menu_enter");

      set_style(STYLE_CURRENCY_TYPE, 0, 8'd0, "cur_mode");
      send_key("6", 1, "cur_6_ignored");
      send_key("3", 1, "cur_3");
      send_key(8'h0D, 1, "cur_enter");

      set_style(STYLE_ACC_NUMBER, 0, 8'd0, "abort_acc");
      send_key("1", 1, "abort_1");
      send_key("2", 1, "abort_2");
      set_style(STYLE_PIN_NUMBER, 1, "3", "abort_change");
      send_key(8'h71, 1, "quit");
      send_key(8'h00, 0, "quit_hold");

      set_style(STYLE_CURRENCY_AMOUNT, 0, 8'd0, "rst_amt");
      send_key("4", 1, "rst_4");
      send_key("2", 1, "rst_2");
      do_reset("mid_reset");
      set_style(STYLE_CURRENCY_AMOUNT, 0, 8'd0, "post_reset");
      send_key("7", 0, "no_strobe");

      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 14) == 0) begin
            logic [3:0] s;
            s = 4'((int'(m_mode) + 1 + int'($urandom_range(0, 5))) % 7);
            set_style(s, bit'($urandom_range(0, 1)), pool[$urandom_range(0, 19)],
                      $sformatf("rnd_style%0d", i));
         end else begin
            send_key(pool[$urandom_range(0, 19)], $urandom_range(0, 9) != 0,
                     $sformatf("rnd_key%0d", i));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
